// File: rtl/wptr_full.sv
`default_nettype none
// ============================================================================
// Module   : wptr_full
// Purpose  : Write-domain pointer and full-flag generator for an asynchronous
//            FIFO. Keeps the binary write pointer, publishes its Gray form for
//            the read-domain synchronizer and derives full, fill level and a
//            sticky overflow flag from the synchronized read pointer.
// Ports    : clk          - write-domain clock
//            rst          - synchronous active-high reset
//            winc         - producer write request
//            rq2_wptr     - Gray read pointer synchronized into clk domain
//            wr_en        - RAM write enable (winc & ~wfull), combinational
//            waddr        - RAM write address (low SIZE bits of binary ptr)
//            wptr         - registered Gray write pointer
//            wfull        - registered full flag
//            wlevel       - registered fill level, 0..2**SIZE
//            wovf         - sticky overflow (write requested while full)
//            walmost_full - registered almost-full flag (optional)
// Options  : define WPTR_ALMOST_FULL_EN to add walmost_full (uses AF_THRESH).
// Revision : 1.0 - initial release
// ============================================================================
module wptr_full #(
  parameter int SIZE      = 4,
  parameter int AF_THRESH = 14
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            winc,
  input  logic [SIZE:0]   rq2_wptr,
  output logic            wr_en,
  output logic [SIZE-1:0] waddr,
  output logic [SIZE:0]   wptr,
  output logic            wfull,
  output logic [SIZE:0]   wlevel,
`ifdef WPTR_ALMOST_FULL_EN
  output logic            walmost_full,
`endif
  output logic            wovf
);

  logic [SIZE:0] wbin;
  logic [SIZE:0] wbin_next;
  logic [SIZE:0] wgray_next;
  logic [SIZE:0] rbin;
  logic [SIZE:0] level_next;
  logic          acc;
  logic          full_next;

  assign acc        = winc & ~wfull;
  assign wr_en      = acc;
  assign waddr      = wbin[SIZE-1:0];
  assign wbin_next  = wbin + (SIZE+1)'(acc);
  assign wgray_next = wbin_next ^ (wbin_next >> 1);

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= SIZE; i++) begin
      rbin[i] = ^(rq2_wptr >> i);
    end
  end

  // Full when the next write pointer has lapped the read pointer exactly once:
  // in Gray form that is the top two bits inverted and the rest equal.
  assign full_next  = (wgray_next == {~rq2_wptr[SIZE:SIZE-1], rq2_wptr[SIZE-2:0]});
  assign level_next = wbin_next - rbin;

  always_ff @(posedge clk) begin
    if (rst) begin
      wbin   <= '0;
      wptr   <= '0;
      wfull  <= 1'b0;
      wlevel <= '0;
      wovf   <= 1'b0;
    end else begin
      wbin   <= wbin_next;
      wptr   <= wgray_next;
      wfull  <= full_next;
      wlevel <= level_next;
      wovf   <= wovf | (winc & wfull);
    end
  end

`ifdef WPTR_ALMOST_FULL_EN
  logic af_next;

  assign af_next = (level_next >= (SIZE+1)'(AF_THRESH));

  always_ff @(posedge clk) begin
    if (rst) begin
      walmost_full <= 1'b0;
    end else begin
      walmost_full <= af_next;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wptr_full.sv
`default_nettype none
// ============================================================================
// Module   : tb_wptr_full
// Purpose  : Directed, table-driven bench for wptr_full (SIZE=4, AF_THRESH=14).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wptr_full;

  localparam int SIZE = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            winc;
  logic [SIZE:0]   rq2_wptr;
  logic            wr_en;
  logic [SIZE-1:0] waddr;
  logic [SIZE:0]   wptr;
  logic            wfull;
  logic [SIZE:0]   wlevel;
  logic            wovf;
`ifdef WPTR_ALMOST_FULL_EN
  logic            walmost_full;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wptr_full #(.SIZE(SIZE), .AF_THRESH(14)) dut (
    .clk          (clk),
    .rst          (rst),
    .winc         (winc),
    .rq2_wptr     (rq2_wptr),
    .wr_en        (wr_en),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .wlevel       (wlevel),
`ifdef WPTR_ALMOST_FULL_EN
    .walmost_full (walmost_full),
`endif
    .wovf         (wovf)
  );

  typedef struct {
    logic       rst;
    logic       winc;
    logic [4:0] rq2;
    logic       wr_en;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic [4:0] wlevel;
    logic       wovf;
    logic       af;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs away from the edge, check combinational outputs, then clock
  // and check the registered outputs.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst      = v.rst;
    winc     = v.winc;
    rq2_wptr = v.rq2;
    #1;
    chk($sformatf("v%0d wr_en", idx), 32'(wr_en), 32'(v.wr_en));
    chk($sformatf("v%0d waddr", idx), 32'(waddr), 32'(v.waddr));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d wptr", idx),   32'(wptr),   32'(v.wptr));
    chk($sformatf("v%0d wfull", idx),  32'(wfull),  32'(v.wfull));
    chk($sformatf("v%0d wlevel", idx), 32'(wlevel), 32'(v.wlevel));
    chk($sformatf("v%0d wovf", idx),   32'(wovf),   32'(v.wovf));
`ifdef WPTR_ALMOST_FULL_EN
    chk($sformatf("v%0d walmost_full", idx), 32'(walmost_full), 32'(v.af));
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; winc = 1'b0; rq2_wptr = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [4:0] bin2gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] gseq [16];
    logic [4:0] prev;
    logic [4:0] wb;
    gseq = '{5'd1, 5'd3, 5'd2, 5'd6, 5'd7, 5'd5, 5'd4, 5'd12,
             5'd13, 5'd15, 5'd14, 5'd10, 5'd11, 5'd9, 5'd8, 5'd24};

    // Reset with winc high; wr_en follows winc once wfull has cleared.
    tbl.push_back('{1'b1, 1'b1, 5'd0, 1'b1, 4'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 5'd0, 1'b1, 4'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0});
    // Fill 16 entries with the read pointer parked at 0.
    for (int k = 0; k < 16; k++) begin
      tbl.push_back('{1'b0, 1'b1, 5'd0, 1'b1, 4'(k), gseq[k], (k == 15),
                      5'(k + 1), 1'b0, (k + 1 >= 14)});
    end
    // 17th write rejected: pointer frozen, overflow set.
    tbl.push_back('{1'b0, 1'b1, 5'd0, 1'b0, 4'd0, 5'd24, 1'b1, 5'd16, 1'b1, 1'b1});
    // Idle: overflow sticky.
    tbl.push_back('{1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 5'd24, 1'b1, 5'd16, 1'b1, 1'b1});
    // One read arrives through the synchronizer: full releases, level 15.
    tbl.push_back('{1'b0, 1'b0, 5'd1, 1'b0, 4'd0, 5'd24, 1'b0, 5'd15, 1'b1, 1'b1});
    // Refill one entry: binary 17 -> Gray 11001, full again.
    tbl.push_back('{1'b0, 1'b1, 5'd1, 1'b1, 4'd0, 5'd25, 1'b1, 5'd16, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 5'd1, 1'b0, 4'd1, 5'd25, 1'b1, 5'd16, 1'b1, 1'b1});

    rst = 1'b1; winc = 1'b1; rq2_wptr = '0;
    @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Wrap: reader trails the writer by one entry across 40 writes.
    do_reset();
    chk("wrap start wptr", 32'(wptr), 32'd0);
    prev = '0;
    wb   = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      winc = 1'b1;
      rq2_wptr = bin2gray(wb);
      @(posedge clk);
      #1;
      wb = wb + 5'd1;
      chk($sformatf("wrap%0d wptr", i), 32'(wptr), 32'(bin2gray(wb)));
      chk($sformatf("wrap%0d onebit", i), 32'($countones(wptr ^ prev)), 32'd1);
      chk($sformatf("wrap%0d wfull", i), 32'(wfull), 32'd0);
      chk($sformatf("wrap%0d wlevel", i), 32'(wlevel), 32'd1);
      prev = wptr;
    end

    // Simultaneous write and read-pointer advance keeps the level steady.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      winc = 1'b1; rq2_wptr = '0;
      @(posedge clk);
    end
    #1;
    chk("simul pre wlevel", 32'(wlevel), 32'd8);
    @(negedge clk);
    winc = 1'b1; rq2_wptr = 5'd1;
    @(posedge clk);
    #1;
    chk("simul wlevel", 32'(wlevel), 32'd8);
    chk("simul wptr", 32'(wptr), 32'd13);
    chk("simul wfull", 32'(wfull), 32'd0);

`ifdef WPTR_ALMOST_FULL_EN
    // Almost-full rises at 14 and clears when the level returns to 13.
    do_reset();
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      winc = 1'b1; rq2_wptr = '0;
      @(posedge clk);
      #1;
      if (i == 13) chk("af at 13", 32'(walmost_full), 32'd0);
      if (i == 14) chk("af at 14", 32'(walmost_full), 32'd1);
    end
    @(negedge clk);
    winc = 1'b0; rq2_wptr = 5'd1;
    @(posedge clk);
    #1;
    chk("af level 13 lvl", 32'(wlevel), 32'd13);
    chk("af back to 13", 32'(walmost_full), 32'd0);
`endif

    @(negedge clk);
    winc = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wptr_full.md
Name: wptr_full

Overview:
- Write-domain pointer and full-flag generator for the asynchronous FIFO.
- Sits upstream of the double-flop synchronizer: its registered Gray write pointer crosses into the read domain through that synchronizer.
- Consumes the read pointer already synchronized into the write domain.
- Produces the RAM write address, the write enable, the full flag, the fill level and a sticky overflow error.

Parameters:
- SIZE, 4, address width; FIFO depth = 2**SIZE; pointers are SIZE+1 bits; legal range SIZE >= 2.
- AF_THRESH, 14, almost-full threshold in entries; legal range 1..2**SIZE; used only with the optional feature.

Ports:
- clk  input  1  write-domain clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- winc  input  1  write request from producer.
- rq2_wptr  input  SIZE+1  read pointer (Gray) after two-flop synchronization into clk domain.
- wr_en  output  1  RAM write enable; combinational, = winc & ~wfull.
- waddr  output  SIZE  RAM write address; = wbin[SIZE-1:0].
- wptr  output  SIZE+1  registered Gray write pointer, fed to the read-domain synchronizer.
- wfull  output  1  registered full flag.
- wlevel  output  SIZE+1  registered fill level, 0..2**SIZE.
- wovf  output  1  sticky overflow flag.
- walmost_full  output  1  registered almost-full flag; present only with WPTR_ALMOST_FULL_EN.

Behaviour:
- Reset: on a clk edge with rst=1, wbin, wptr, wfull, wlevel, wovf and walmost_full all clear to 0. rst dominates winc in the same cycle.
- Accept: acc = winc & ~wfull. wbin_next = wbin + acc, modulo 2**(SIZE+1); the MSB is the wrap bit.
- Gray encoding: wgray_next = wbin_next ^ (wbin_next >> 1). wptr <= wgray_next every cycle.
  - wptr changes by at most one bit per clk; this is required for a safe crossing.
- Full: wfull <= (wgray_next == {~rq2_wptr[SIZE:SIZE-1], rq2_wptr[SIZE-2:0]}).
  - wfull asserts on the same edge that accepts the 2**SIZE-th outstanding entry.
  - No write is accepted while wfull=1.
- Full release is pessimistic: wfull deasserts only once the advanced read pointer arrives through the synchronizer. Two or more clk of delay after the read is normal and correct.
- Level: rbin = Gray-to-binary of rq2_wptr (combinational XOR prefix).
  - wlevel <= wbin_next - rbin, computed mod 2**(SIZE+1).
  - Always within 0..2**SIZE; wlevel == 2**SIZE iff wfull.
- Overflow: wovf <= wovf | (winc & wfull). Cleared only by rst. The rejected write does not move wbin.
- Latency: wptr, wfull and wlevel all reflect an accepted write on the edge that accepts it. wr_en and waddr are valid in the request cycle.
- Wrap-around: wbin rolls from 2**(SIZE+1)-1 to 0 with no glitch on wfull. The full compare relies solely on the MSB and second-MSB inversion.
- Simultaneous write and read-pointer update in one cycle: full and level use the new rq2_wptr together with wbin_next.
- rq2_wptr is not reset here; the synchronizer resets it. Mid-operation rst of this block alone restarts at pointer 0. The system must reset both domains together.

Optional Feature:
- Macro: WPTR_ALMOST_FULL_EN.
- Defined:
  - Port walmost_full exists.
  - walmost_full <= (wbin_next - rbin) >= AF_THRESH; it is registered alongside wfull and reset to 0.
  - It stays asserted while wfull=1.
- Undefined: the port, its register and the comparator are absent. AF_THRESH is ignored.

Test Plan:
- Reset: hold rst=1 with winc=1 for 3 clk -> wptr=0, waddr=0, wfull=0, wlevel=0, wovf=0; wr_en follows winc.
- Fill (rq2_wptr=0): 16 cycles winc=1 -> waddr 0..15; wptr Gray sequence 0,1,3,2,6,…; wfull=1 and wlevel=16 on the edge of the 16th accept; 17th winc -> wr_en=0, wbin unchanged, wovf=1 and stays 1.
- Drain release: full, then drive rq2_wptr=5'b00001 -> next edge wfull=0, wlevel=15; one write -> wfull=1 again, wptr=5'b11001 (binary 17).
- Wrap: read tracks writes at 1-entry lag for 40 writes -> wbin passes 31->0; wptr single-bit changes throughout; wfull never asserts; wlevel stays 1.
- Simultaneous: wlevel=8, winc=1 and rq2_wptr advances one in the same cycle -> wlevel stays 8.
- WPTR_ALMOST_FULL_EN with AF_THRESH=14: fill from empty -> walmost_full=0 at level 13, =1 at level 14; stays 1 at 16; clears when level returns to 13.
